// File: rtl/dropout_pkg.sv
// Shared types and constants for the dropout mask generator.
package dropout_pkg;

    localparam int unsigned DROPOUT_N_NEURONS = 8;
    localparam int unsigned DROPOUT_LFSR_W    = 16;
    localparam int unsigned DROPOUT_RND_W     = 8;
    localparam int unsigned DROPOUT_IDX_W     = 3;
    localparam int unsigned DROPOUT_ZCNT_W    = 4;
    localparam int unsigned DROPOUT_STATS_W   = 16;

    localparam logic [DROPOUT_LFSR_W-1:0] DROPOUT_LFSR_TAPS    = 16'hB400;
    localparam logic [DROPOUT_LFSR_W-1:0] DROPOUT_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        VALID = 2'd2
    } state_e;

    // Number of dropped neurons (zero bits) in a mask.
    function automatic logic [DROPOUT_ZCNT_W-1:0] count_zeros(
        input logic [DROPOUT_N_NEURONS-1:0] m
    );
        logic [DROPOUT_ZCNT_W-1:0] zeros;
        zeros = '0;
        for (int i = 0; i < int'(DROPOUT_N_NEURONS); i++) begin
            zeros = zeros + DROPOUT_ZCNT_W'(~m[i]);
        end
        return zeros;
    endfunction

endpackage

// File: rtl/dropout_lfsr.sv
// Galois LFSR supplying random bytes to the mask generator.
// A load takes priority over a step; a zero seed is replaced by the default seed.
module dropout_lfsr
    import dropout_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      step,
    input  logic [DROPOUT_LFSR_W-1:0] seed,
    output logic [DROPOUT_LFSR_W-1:0] lfsr
);

    logic [DROPOUT_LFSR_W-1:0] lfsr_q;
    logic [DROPOUT_LFSR_W-1:0] lfsr_d;

    // Next LFSR value: seed load, feedback step, or hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == '0) ? DROPOUT_SEED_DEFAULT : seed;
        end else if (step) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? DROPOUT_LFSR_TAPS : '0);
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= DROPOUT_SEED_DEFAULT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/dropout_mask_gen.sv
// Per-neuron keep/drop mask generator for the dropout stage.
// Optional feature: define DROPOUT_MASK_STATS_EN to add the drop_count output.
module dropout_mask_gen
    import dropout_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [DROPOUT_RND_W-1:0]     keep_thresh,
    input  logic                         seed_load,
    input  logic [DROPOUT_LFSR_W-1:0]    seed,
    output logic [DROPOUT_N_NEURONS-1:0] mask,
    output logic                         mask_valid,
    input  logic                         mask_ready,
    output logic                         busy
`ifdef DROPOUT_MASK_STATS_EN
    ,
    output logic [DROPOUT_STATS_W-1:0]   drop_count
`endif
);

    state_e                         state_q, state_d;
    logic [DROPOUT_IDX_W-1:0]       bit_q, bit_d;
    logic [DROPOUT_N_NEURONS-1:0]   shadow_q, shadow_d;
    logic [DROPOUT_N_NEURONS-1:0]   mask_q, mask_d;
    logic [DROPOUT_RND_W-1:0]       thr_q, thr_d;
    logic                           en_q, en_d;
    logic                           valid_q, valid_d;
    logic                           busy_q, busy_d;

    logic [DROPOUT_LFSR_W-1:0]      lfsr;
    logic [DROPOUT_RND_W-1:0]       rnd_c;
    logic                           keep_c;
    logic                           step_c;
    logic                           handshake_c;
    logic                           lfsr_hi_unused;

    dropout_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (seed_load),
        .step  (step_c),
        .seed  (seed),
        .lfsr  (lfsr)
    );

    assign rnd_c          = lfsr[DROPOUT_RND_W-1:0];
    assign lfsr_hi_unused = ^lfsr[DROPOUT_LFSR_W-1:DROPOUT_RND_W];
    assign keep_c         = (thr_q == '1) | (rnd_c < thr_q);
    assign handshake_c    = valid_q & mask_ready;

    // FSM next state, per-bit mask build and LFSR step request.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        thr_d    = thr_q;
        en_d     = en_q;
        step_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = GEN;
                en_d    = enable;
                thr_d   = keep_thresh;
                bit_d   = '0;
            end
            GEN: begin
                if (seed_load) begin
                    // Discard the in-flight mask and restart from bit 0.
                    en_d  = enable;
                    thr_d = keep_thresh;
                    bit_d = '0;
                end else if (!en_q) begin
                    mask_d  = '1;
                    state_d = VALID;
                end else begin
                    step_c          = 1'b1;
                    shadow_d[bit_q] = keep_c;
                    if (bit_q == DROPOUT_IDX_W'(DROPOUT_N_NEURONS - 1)) begin
                        mask_d  = shadow_d;
                        state_d = VALID;
                    end else begin
                        bit_d = bit_q + DROPOUT_IDX_W'(1);
                    end
                end
            end
            VALID: begin
                if (handshake_c) begin
                    state_d = GEN;
                    en_d    = enable;
                    thr_d   = keep_thresh;
                    bit_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == VALID);
        busy_d  = (state_d == GEN);
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            shadow_q <= '0;
            mask_q   <= '0;
            thr_q    <= '0;
            en_q     <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            thr_q    <= thr_d;
            en_q     <= en_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign mask       = mask_q;
    assign mask_valid = valid_q;
    assign busy       = busy_q;

`ifdef DROPOUT_MASK_STATS_EN
    logic [DROPOUT_STATS_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DROPOUT_STATS_W:0]   drop_sum_c;

    // Saturating count of dropped neurons over accepted masks.
    always_comb begin
        drop_sum_c = (DROPOUT_STATS_W + 1)'(drop_cnt_q)
                   + (DROPOUT_STATS_W + 1)'(count_zeros(mask_q));
        drop_cnt_d = drop_cnt_q;
        if (handshake_c) begin
            drop_cnt_d = drop_sum_c[DROPOUT_STATS_W] ? '1
                                                     : drop_sum_c[DROPOUT_STATS_W-1:0];
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
